// File: rtl/ram_mrmw_init.sv
// Multi-read/multi-write register-file RAM with a hardware init sweep after reset or on init_i.
// Optional RAM_MRMW_BYPASS_EN forwards same-cycle write data to matching read ports.
module ram_mrmw_init #(
    parameter int                 RPORT    = 4,
    parameter int                 WPORT    = 2,
    parameter int                 DEPTH    = 64,
    parameter int                 INDEX    = 6,
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   INIT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init_i,
    output logic                    busy_o,
    input  logic [RPORT*INDEX-1:0]  raddr_i,
    output logic [RPORT*WIDTH-1:0]  rdata_o,
    input  logic [WPORT-1:0]        we_i,
    input  logic [WPORT*INDEX-1:0]  waddr_i,
    input  logic [WPORT*WIDTH-1:0]  wdata_i
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam logic [INDEX:0] LAST_CNT = (INDEX+1)'(DEPTH - 1);
    localparam logic [INDEX:0] DEPTH_W  = (INDEX+1)'(DEPTH);

    state_e           state_q;
    logic [INDEX:0]   cnt_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    function automatic logic in_range(input logic [INDEX-1:0] addr);
        return {1'b0, addr} < DEPTH_W;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else if (state_q == CLEAR) begin
            if (cnt_q == LAST_CNT) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (init_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end
    end

    assign busy_o = (state_q == CLEAR);

    // Later ports overwrite earlier ones in the loop, so the highest enabled port wins a conflict.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q[INDEX-1:0]] <= INIT_VAL;
        end else begin
            for (int w = 0; w < WPORT; w++) begin
                if (we_i[w] && in_range(waddr_i[w*INDEX +: INDEX])) begin
                    mem_q[waddr_i[w*INDEX +: INDEX]] <= wdata_i[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    for (genvar gi = 0; gi < RPORT; gi++) begin : g_rd
        logic [INDEX-1:0] raddr;
        logic [WIDTH-1:0] rdata;

        assign raddr = raddr_i[gi*INDEX +: INDEX];

        always_comb begin
            rdata = INIT_VAL;
            if (state_q == IDLE && in_range(raddr)) begin
                rdata = mem_q[raddr];
`ifdef RAM_MRMW_BYPASS_EN
                for (int w = 0; w < WPORT; w++) begin
                    if (we_i[w] && waddr_i[w*INDEX +: INDEX] == raddr) begin
                        rdata = wdata_i[w*WIDTH +: WIDTH];
                    end
                end
`endif
            end
        end

        assign rdata_o[gi*WIDTH +: WIDTH] = rdata;
    end

endmodule
